// File: rtl/vx_barrier_ctl.sv
// ---------------------------------------------------------------------------
// vx_barrier_ctl
//
// Purpose:
//   Warp barrier controller. Each barrier slot counts arriving warps and
//   remembers which warps are blocked on it. When the last participant
//   arrives, the slot releases every waiting warp (plus the last arrival)
//   with a single-cycle pulse one cycle after the arrival.
//
// Parameters:
//   WARP_CNT      number of warps tracked (default `NUM_WARPS)
//   NUM_BARRIERS  number of barrier slots (default `NUM_BARRIERS)
//   BAR_BITS      derived, width of a slot index
//   WID_BITS      derived, width of a warp id / participant count
//
// Ports:
//   clk            single clock, all logic on its rising edge
//   reset          synchronous active-high reset
//   bar_valid      barrier arrival, one per cycle, always accepted
//   bar_wid        arriving warp id
//   bar_id         barrier slot addressed by the arrival
//   bar_size_m1    participating warps minus one
//   flush          clears all barrier state, drops a simultaneous arrival
//   stalled_warps  registered mask of warps blocked at any barrier
//   release_valid  one-cycle pulse when a barrier completes
//   release_mask   warps unblocked by that release, zero otherwise
//   perf_bar_stalls (BARRIER_PERF_EN only) accumulated stalled warp-cycles
//
// Configuration:
//   Define BARRIER_PERF_EN to add the perf_bar_stalls counter port.
//   Without it the port and counter are absent; behaviour is otherwise
//   identical.
// ---------------------------------------------------------------------------

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

`ifndef NUM_BARRIERS
`define NUM_BARRIERS 4
`endif

`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 32
`endif

module vx_barrier_ctl #(
  parameter int WARP_CNT     = `NUM_WARPS,
  parameter int NUM_BARRIERS = `NUM_BARRIERS,
  localparam int BAR_BITS    = `LOG2UP(NUM_BARRIERS),
  localparam int WID_BITS    = `LOG2UP(WARP_CNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bar_valid,
  input  logic [WID_BITS-1:0] bar_wid,
  input  logic [BAR_BITS-1:0] bar_id,
  input  logic [WID_BITS-1:0] bar_size_m1,
  input  logic                flush,
  output logic [WARP_CNT-1:0] stalled_warps,
  output logic                release_valid,
  output logic [WARP_CNT-1:0] release_mask
`ifdef BARRIER_PERF_EN
  ,
  output logic [`PERF_CTR_BITS-1:0] perf_bar_stalls
`endif
);

  // Per-slot barrier state. A slot is idle when both count and wait_mask
  // are zero; otherwise it is collecting participants.
  logic [WID_BITS-1:0] count     [NUM_BARRIERS];
  logic [WARP_CNT-1:0] wait_mask [NUM_BARRIERS];

  // Decode of the current arrival against its addressed slot.
  logic [WARP_CNT-1:0] wid_bit;
  logic [WID_BITS-1:0] slot_count;
  logic [WARP_CNT-1:0] slot_wait;
  logic                dup_arrival;
  logic                other_stall;
  logic                slot_complete;
  logic                accept;

  always_comb begin
    wid_bit       = '0;
    wid_bit       = WARP_CNT'(1) << bar_wid;
    slot_count    = count[bar_id];
    slot_wait     = wait_mask[bar_id];
    // A warp that is already waiting on this slot must not count twice.
    dup_arrival   = |(slot_wait & wid_bit);
    // Warp blocked elsewhere: legal to process, but flagged as a usage error.
    other_stall   = (|(stalled_warps & wid_bit)) && !dup_arrival;
    // The size is re-sampled on every arrival; using >= keeps the count from
    // ever running past a size that shrank between arrivals.
    slot_complete = (slot_count >= bar_size_m1);
    accept        = bar_valid && !dup_arrival;
  end

  // Arrival / release stage: all outputs registered, one cycle after arrival.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // Reset and flush both discard waiting warps without a release; the
      // arrival presented in the same cycle is dropped.
      for (int s = 0; s < NUM_BARRIERS; s++) begin
        count[s]     <= '0;
        wait_mask[s] <= '0;
      end
      stalled_warps <= '0;
      release_valid <= 1'b0;
      release_mask  <= '0;
    end else begin
      release_valid <= 1'b0;
      release_mask  <= '0;
      if (accept) begin
        if (slot_complete) begin
          release_valid     <= 1'b1;
          release_mask      <= slot_wait | wid_bit;
          count[bar_id]     <= '0;
          wait_mask[bar_id] <= '0;
          stalled_warps     <= stalled_warps & ~(slot_wait | wid_bit);
        end else begin
          count[bar_id]     <= slot_count + WID_BITS'(1);
          wait_mask[bar_id] <= slot_wait | wid_bit;
          stalled_warps     <= stalled_warps | wid_bit;
        end
      end
    end
  end

  // Usage checks on arrivals that the datapath will actually see.
  always_ff @(posedge clk) begin
    if (!reset && !flush && bar_valid) begin
      assert (!dup_arrival)
        else $warning("vx_barrier_ctl: warp %0d already waiting on slot %0d, arrival ignored",
                      bar_wid, bar_id);
      assert (!other_stall)
        else $warning("vx_barrier_ctl: warp %0d already blocked on another slot", bar_wid);
    end
  end

`ifdef BARRIER_PERF_EN
  function automatic logic [`PERF_CTR_BITS-1:0] popcount(input logic [WARP_CNT-1:0] v);
    logic [`PERF_CTR_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < WARP_CNT; i++) begin
      n = n + {{(`PERF_CTR_BITS-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Stall accounting: survives flush, only reset clears it; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bar_stalls <= '0;
    end else begin
      perf_bar_stalls <= perf_bar_stalls + popcount(stalled_warps);
    end
  end
`endif

endmodule

// File: tb/tb_vx_barrier_ctl.sv
`timescale 1ns/1ps

`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 32
`endif

module tb_vx_barrier_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bar_valid = 1'b0;
  logic [1:0] bar_wid = '0;
  logic [1:0] bar_id = '0;
  logic [1:0] bar_size_m1 = '0;
  logic       flush = 1'b0;
  logic [3:0] stalled_warps;
  logic       release_valid;
  logic [3:0] release_mask;
`ifdef BARRIER_PERF_EN
  logic [`PERF_CTR_BITS-1:0] perf_bar_stalls;
`endif

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       rv;
    logic [3:0] rm;
    logic [3:0] st;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];

  vx_barrier_ctl #(
    .WARP_CNT(4),
    .NUM_BARRIERS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bar_valid(bar_valid),
    .bar_wid(bar_wid),
    .bar_id(bar_id),
    .bar_size_m1(bar_size_m1),
    .flush(flush),
    .stalled_warps(stalled_warps),
    .release_valid(release_valid),
    .release_mask(release_mask)
`ifdef BARRIER_PERF_EN
    ,
    .perf_bar_stalls(perf_bar_stalls)
`endif
  );

  always #5 clk = ~clk;

  // One clock of stimulus: the expected outputs after this edge go on the
  // scoreboard, the observed outputs are captured 1ns after the edge.
  task automatic step(input logic v, input int w, input int id, input int sz,
                      input logic fl, input logic rs,
                      input logic erv, input logic [3:0] erm, input logic [3:0] est);
    bar_valid   = v;
    bar_wid     = 2'(w);
    bar_id      = 2'(id);
    bar_size_m1 = 2'(sz);
    flush       = fl;
    reset       = rs;
    exp_q.push_back('{erv, erm, est});
    @(posedge clk);
    #1;
    obs_q.push_back('{release_valid, release_mask, stalled_warps});
    bar_valid = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    out_t e, o;
    int k = 0;
    step(1, 2, 1, 1, 0, 1, 0, 4'b0000, 4'b0000);
    step(1, 3, 1, 0, 1, 1, 0, 4'b0000, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL reset[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL reset[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL reset[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_basic_release();
    out_t e, o;
    int k = 0;
    step(1, 0, 1, 2, 0, 0, 0, 4'b0000, 4'b0001);
    step(1, 1, 1, 2, 0, 0, 0, 4'b0000, 4'b0011);
    step(1, 2, 1, 2, 0, 0, 1, 4'b0111, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL basic[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL basic[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL basic[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_immediate();
    out_t e, o;
    int k = 0;
    step(1, 3, 0, 0, 0, 0, 1, 4'b1000, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL immediate[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL immediate[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL immediate[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_interleave();
    out_t e, o;
    int k = 0;
    step(1, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0001);
    step(1, 1, 1, 1, 0, 0, 0, 4'b0000, 4'b0011);
    step(1, 2, 0, 1, 0, 0, 1, 4'b0101, 4'b0010);
    step(1, 3, 1, 1, 0, 0, 1, 4'b1010, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL interleave[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL interleave[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL interleave[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_flush();
    out_t e, o;
    int k = 0;
    step(1, 0, 2, 3, 0, 0, 0, 4'b0000, 4'b0001);
    step(1, 1, 2, 3, 0, 0, 0, 4'b0000, 4'b0011);
    step(1, 2, 2, 3, 1, 0, 0, 4'b0000, 4'b0000);
    // Count restarts from zero: four fresh arrivals are needed to release.
    step(1, 0, 2, 3, 0, 0, 0, 4'b0000, 4'b0001);
    step(1, 1, 2, 3, 0, 0, 0, 4'b0000, 4'b0011);
    step(1, 2, 2, 3, 0, 0, 0, 4'b0000, 4'b0111);
    step(1, 3, 2, 3, 0, 0, 1, 4'b1111, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL flush[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL flush[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL flush[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_duplicate();
    out_t e, o;
    int k = 0;
    step(1, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0010);
    step(1, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0010);
    // Count stayed at 1, so a single further arrival completes the slot.
    step(1, 2, 0, 1, 0, 0, 1, 4'b0110, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL duplicate[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL duplicate[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL duplicate[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    int k = 0;
    step(1, 0, 3, 0, 0, 0, 1, 4'b0001, 4'b0000);
    step(1, 1, 3, 0, 0, 0, 1, 4'b0010, 4'b0000);
    step(1, 2, 1, 1, 0, 0, 0, 4'b0000, 4'b0100);
    step(1, 3, 2, 0, 0, 0, 1, 4'b1000, 4'b0100);
    step(1, 0, 1, 1, 0, 0, 1, 4'b0101, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL back_to_back[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL back_to_back[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL back_to_back[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    out_t e, o;
    int k = 0;
    step(1, 0, 1, 2, 0, 0, 0, 4'b0000, 4'b0001);
    step(1, 1, 1, 2, 0, 0, 0, 4'b0000, 4'b0011);
    step(1, 2, 1, 2, 0, 1, 0, 4'b0000, 4'b0000);
    step(1, 2, 1, 2, 0, 0, 0, 4'b0000, 4'b0100);
    step(1, 3, 1, 2, 0, 0, 0, 4'b0000, 4'b1100);
    step(1, 0, 1, 2, 0, 0, 1, 4'b1101, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests += 3;
      if (o.rv !== e.rv) begin failed++; $display("FAIL reset_mid[%0d] release_valid got %b want %b", k, o.rv, e.rv); end
      if (o.rm !== e.rm) begin failed++; $display("FAIL reset_mid[%0d] release_mask got %b want %b", k, o.rm, e.rm); end
      if (o.st !== e.st) begin failed++; $display("FAIL reset_mid[%0d] stalled_warps got %b want %b", k, o.st, e.st); end
      k++;
    end
  endtask

`ifdef BARRIER_PERF_EN
  task automatic test_perf();
    exp_q.delete(); obs_q.delete();
    step(0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000);
    tests++;
    if (perf_bar_stalls !== '0) begin failed++; $display("FAIL perf_reset got %0d want 0", perf_bar_stalls); end
    // w0 stalls at the first edge (adds 0), w1 at the second (adds 1).
    step(1, 0, 2, 3, 0, 0, 0, 4'b0000, 4'b0001);
    step(1, 1, 2, 3, 0, 0, 0, 4'b0000, 4'b0011);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0011);
    tests++;
    if (perf_bar_stalls !== `PERF_CTR_BITS'(21)) begin
      failed++; $display("FAIL perf_count got %0d want 21", perf_bar_stalls);
    end
    step(0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000);
    tests += 2;
    if (perf_bar_stalls !== '0) begin failed++; $display("FAIL perf_after_reset got %0d want 0", perf_bar_stalls); end
    if (release_valid !== 1'b0) begin failed++; $display("FAIL perf_no_release got %b want 0", release_valid); end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic_release();
    test_immediate();
    test_interleave();
    test_flush();
    test_duplicate();
    test_back_to_back();
    test_reset_mid();
`ifdef BARRIER_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_barrier_ctl.md
VX_BARRIER_CTL -- requirements
Module: vx_barrier_ctl

Interface
REQ-001 SHALL have parameter WARP_CNT, default `NUM_WARPS, number of warps tracked.
REQ-002 SHALL have parameter NUM_BARRIERS, default `NUM_BARRIERS, number of barrier slots; BAR_BITS = `LOG2UP(NUM_BARRIERS); WID_BITS = `LOG2UP(WARP_CNT).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port bar_valid, input, 1, barrier arrival from the warp-control commit path, one per cycle, always accepted.
REQ-006 SHALL have port bar_wid, input, WID_BITS, arriving warp id.
REQ-007 SHALL have port bar_id, input, BAR_BITS, barrier slot.
REQ-008 SHALL have port bar_size_m1, input, WID_BITS, participating warps minus one.
REQ-009 SHALL have port flush, input, 1, clears all barrier state.
REQ-010 SHALL have port stalled_warps, output, WARP_CNT, warps currently blocked at any barrier (registered).
REQ-011 SHALL have port release_valid, output, 1, one-cycle pulse when a barrier completes.
REQ-012 SHALL have port release_mask, output, WARP_CNT, warps unblocked by that release; zero when release_valid low.

Function
REQ-013 SHALL keep per-slot state: count[NUM_BARRIERS] (WID_BITS wide) and wait_mask[NUM_BARRIERS] (WARP_CNT wide); slot is IDLE when count==0 and wait_mask==0, else WAITING.
REQ-014 On bar_valid with count[bar_id] != bar_size_m1: next cycle count[bar_id] += 1, wait_mask[bar_id] and stalled_warps gain bit bar_wid; no release.
REQ-015 On bar_valid with count[bar_id] == bar_size_m1: next cycle release_valid=1, release_mask = wait_mask[bar_id] | (1<<bar_wid), count and wait_mask of slot cleared to IDLE, those bits cleared from stalled_warps.
REQ-016 bar_size_m1==0 SHALL release immediately: release_mask holds only bar_wid; bar_wid never appears in stalled_warps.
REQ-017 Latency arrival-to-release SHALL be exactly 1 cycle; stalled_warps update SHALL coincide with release_valid.
REQ-018 Arrival of a warp already set in wait_mask[bar_id] SHALL be ignored (no count change) and fire a simulation assertion.
REQ-019 Arrival of a warp already stalled on a different slot SHALL fire a simulation assertion; state update per REQ-014/015 still applies.
REQ-020 count SHALL never exceed bar_size_m1; size value sampled on each arrival, the latest arrival's value governs completion.
REQ-021 flush SHALL clear all count, wait_mask, stalled_warps next cycle and suppress release_valid; flush with simultaneous bar_valid drops the arrival.
REQ-022 Other slots SHALL be unaffected by activity on one slot.

Reset
REQ-023 On reset all count and wait_mask SHALL be 0, stalled_warps=0, release_valid=0, release_mask=0.
REQ-024 Reset mid-barrier SHALL discard waiting warps without issuing a release.
REQ-025 Reset SHALL take priority over flush and bar_valid.

Configuration
REQ-026 Macro BARRIER_PERF_EN SHALL gate a performance counter.
REQ-027 With BARRIER_PERF_EN defined: output perf_bar_stalls, `PERF_CTR_BITS wide, SHALL increment by popcount(stalled_warps) each cycle, reset to 0, not cleared by flush, wraps modulo 2^`PERF_CTR_BITS.
REQ-028 Without BARRIER_PERF_EN: port and counter absent; all other behaviour identical.

Verification
REQ-029 WARP_CNT=4: arrivals w0,w1,w2 on bar 1 size_m1=2 in consecutive cycles -> stalled_warps 0001, 0011, then release_valid=1, release_mask=0111, stalled_warps=0000.
REQ-030 Arrival w3 bar 0 size_m1=0 -> next cycle release_valid=1, release_mask=1000, stalled_warps stays 0000.
REQ-031 w0 bar 0 and w1 bar 1 size_m1=1, then w2 bar 0 -> release_mask=0101, stalled_warps=0010.
REQ-032 w0,w1 waiting bar 2 size_m1=3, assert flush with w2 arrival -> stalled_warps=0000, no release, subsequent w0 arrival starts count at 1.
REQ-033 w1 arrives twice on bar 0 size_m1=1 -> assertion fires, count stays 1, no release.
REQ-034 BARRIER_PERF_EN defined, two warps stalled 10 cycles -> perf_bar_stalls=20; reset mid-barrier -> counter 0, no release.
